// File: rtl/sensor_avg_bank_if.sv
// Purpose: bundles the sample, strobe, control and result signals of sensor_avg_bank.
// Latency: none. This is wiring only.
// Backpressure: none. Every signal is a level or a single-cycle pulse, with no ready path.
// Ports: master drives smpl/strb/seed/target/batt/not_pedaling and receives
//        avg/avg_vld/tick/batt_ok/error. The slave modport is the averaging bank.
interface sensor_avg_bank_if #(
  parameter int NCH = 2,
  parameter int DW  = 12
);
  logic [NCH*DW-1:0] smpl;
  logic [NCH-1:0]    strb;
  logic [NCH-1:0]    seed;
  logic [DW-1:0]     target;
  logic [DW-1:0]     batt;
  logic              not_pedaling;
  logic [NCH*DW-1:0] avg;
  logic [NCH-1:0]    avg_vld;
  logic              tick;
  logic              batt_ok;
  logic [DW:0]       error;

  modport master (
    output smpl, strb, seed, target, batt, not_pedaling,
    input  avg, avg_vld, tick, batt_ok, error
  );

  modport slave (
    input  smpl, strb, seed, target, batt, not_pedaling,
    output avg, avg_vld, tick, batt_ok, error
  );
endinterface

// File: rtl/sensor_avg_bank.sv
// Purpose: NCH exponential averagers with a sample timer, battery lockout with hysteresis,
//          and a gated, registered error term (target - avg[ERR_CH]).
// Latency: a sample or seed in cycle n is visible on avg and avg_vld in n+1. error lags avg by 1 cycle.
// Backpressure: none. Each trigger is consumed in the cycle it is present.
// Ports: clk, rst_n (async, active low); bus = slave side of sensor_avg_bank_if
//        (smpl/strb/seed/target/batt/not_pedaling in; avg/avg_vld/tick/batt_ok/error out).
module sensor_avg_bank #(
  parameter int             NCH      = 2,
  parameter int             DW       = 12,
  parameter int             SHIFT    = 5,
  parameter logic [NCH-1:0] MODE     = 'b01,
  parameter int             TMR_W    = 22,
  parameter int             FAST_SIM = 0,
  parameter int             ERR_CH   = 0,
  parameter logic [DW-1:0]  LOW_TH   = 12'hA98,
  parameter logic [DW-1:0]  HYST     = 12'h040
) (
  input  logic              clk,
  input  logic              rst_n,
  sensor_avg_bank_if.slave  bus
);

  localparam int AW = DW + SHIFT;
  // In fast simulation only the low 16 timer bits form the tick. The upper bits then stay at 0.
  localparam int TICK_W = (FAST_SIM != 0 && TMR_W > 16) ? 16 : TMR_W;
  localparam logic [TMR_W-1:0] TMR_ONE = 1;
  // The release threshold is computed one bit wider so that LOW_TH+HYST cannot wrap.
  localparam logic [DW:0] REL_TH = {1'b0, LOW_TH} + {1'b0, HYST};

  // ---------------- sample timer ----------------
  logic [TMR_W-1:0] tmr;
  logic             tick_w;

  assign tick_w   = &tmr[TICK_W-1:0];
  assign bus.tick = tick_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (tick_w) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + TMR_ONE;
    end
  end

  // ---------------- averaging channels ----------------
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DW-1:0] s;
    logic          trig;
    logic [AW-1:0] acc;
    logic          vld;

    assign s    = bus.smpl[i*DW +: DW];
    assign trig = MODE[i] ? bus.strb[i] : tick_w;

    // acc - (acc >> SHIFT) + s stays at or below (2^DW-1) << SHIFT, so AW bits are enough.
    // A seed overrides a trigger in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc <= '0;
        vld <= 1'b0;
      end else begin
        vld <= bus.seed[i] | trig;
        if (bus.seed[i]) begin
          acc <= {s, {SHIFT{1'b0}}};
        end else if (trig) begin
          acc <= acc - (acc >> SHIFT) + {{SHIFT{1'b0}}, s};
        end
      end
    end

    assign bus.avg[i*DW +: DW] = acc[AW-1:SHIFT];
    assign bus.avg_vld[i]      = vld;
  end

  // ---------------- battery lockout ----------------
  typedef enum logic {
    LOCK = 1'b0,
    OK   = 1'b1
  } bstate_t;

  bstate_t state_q;
  bstate_t state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOCK;
    end else begin
      state_q <= state_d;
    end
  end

  // Between LOW_TH and REL_TH the state holds. This gap is the hysteresis band.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOCK:    if ({1'b0, bus.batt} >= REL_TH) state_d = OK;
      OK:      if (bus.batt < LOW_TH)          state_d = LOCK;
      default: state_d = LOCK;
    endcase
  end

  assign bus.batt_ok = (state_q == OK);

  // ---------------- error term ----------------
  logic [DW-1:0] avg_sel;
  logic [DW:0]   error_q;

  assign avg_sel = bus.avg[ERR_CH*DW +: DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= '0;
    end else if (bus.not_pedaling || !bus.batt_ok) begin
      error_q <= '0;
    end else begin
      error_q <= {1'b0, bus.target} - {1'b0, avg_sel};
    end
  end

  assign bus.error = error_q;

endmodule

// File: tb/tb_sensor_avg_bank.sv
// Purpose: checks sensor_avg_bank against a behavioural model, using directed steps plus random stimulus.
// Latency: outputs are compared 1 time unit after each rising clock edge.
// Backpressure: not applicable. The bench drives every input every cycle.
module tb_sensor_avg_bank;
  localparam int             NCH      = 2;
  localparam int             DW       = 12;
  localparam int             SHIFT    = 5;
  localparam logic [NCH-1:0] MODE     = 2'b01;
  localparam int             TMR_W    = 8;
  localparam int             FAST_SIM = 0;
  localparam int             ERR_CH   = 0;
  localparam logic [DW-1:0]  LOW_TH   = 12'hA98;
  localparam logic [DW-1:0]  HYST     = 12'h040;
  localparam int             P        = 1 << TMR_W;

  logic clk;
  logic rst_n;

  sensor_avg_bank_if #(.NCH(NCH), .DW(DW)) bus ();

  sensor_avg_bank #(
    .NCH(NCH), .DW(DW), .SHIFT(SHIFT), .MODE(MODE), .TMR_W(TMR_W),
    .FAST_SIM(FAST_SIM), .ERR_CH(ERR_CH), .LOW_TH(LOW_TH), .HYST(HYST)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model. The accumulator is a plain integer, and the timer is the count of edges modulo P.
  int unsigned m_acc [NCH];
  logic [NCH-1:0] m_vld;
  int          m_tmr;
  bit          m_ok;
  logic [DW:0] m_err;
  int          ncyc;
  int          tick_at [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) m_acc[c] = 0;
    m_vld = '0;
    m_tmr = 0;
    m_ok  = 0;
    m_err = '0;
    ncyc  = 0;
  endtask

  // Advance one clock edge, update the model from the inputs seen at that edge, then compare all outputs.
  task automatic step();
    logic [NCH-1:0]    mode_v;
    logic [NCH*DW-1:0] e_avg;
    logic [DW-1:0]     s;
    bit                tk;
    bit                trig;
    int                d;
    int unsigned       avg_e;
    mode_v = MODE;
    @(posedge clk);
    if (rst_n) begin
      tk    = (m_tmr == P - 1);
      avg_e = m_acc[ERR_CH] / (1 << SHIFT);
      d     = int'(bus.target) - int'(avg_e);
      m_err = (bus.not_pedaling || !m_ok) ? '0 : d[DW:0];
      for (int c = 0; c < NCH; c++) begin
        s    = bus.smpl[c*DW +: DW];
        trig = mode_v[c] ? bus.strb[c] : tk;
        if (bus.seed[c])  m_acc[c] = int'(s) * (1 << SHIFT);
        else if (trig)    m_acc[c] = m_acc[c] - m_acc[c] / (1 << SHIFT) + int'(s);
        m_vld[c] = bus.seed[c] | trig;
      end
      if (!m_ok && int'(bus.batt) >= int'(LOW_TH) + int'(HYST)) m_ok = 1;
      else if (m_ok && int'(bus.batt) < int'(LOW_TH))           m_ok = 0;
      m_tmr = tk ? 0 : m_tmr + 1;
      ncyc++;
    end
    #1;
    for (int c = 0; c < NCH; c++) e_avg[c*DW +: DW] = DW'(m_acc[c] / (1 << SHIFT));
    chk("avg", bus.avg, e_avg);
    chk("avg_vld", bus.avg_vld, m_vld);
    chk("tick", bus.tick, (m_tmr == P - 1));
    chk("batt_ok", bus.batt_ok, m_ok);
    chk("error", bus.error, m_err);
    if (rst_n && bus.tick === 1'b1) begin
      if (tick_at[0] < 0)      tick_at[0] = ncyc;
      else if (tick_at[1] < 0) tick_at[1] = ncyc;
    end
  endtask

  logic [DW-1:0] prev0;
  logic [DW-1:0] bseq [5];
  logic          bexp [5];

  initial begin
    tick_at[0] = -1;
    tick_at[1] = -1;
    model_reset();
    rst_n            = 1'b0;
    bus.smpl         = '0;
    bus.strb         = '0;
    bus.seed         = '0;
    bus.target       = '0;
    bus.batt         = '0;
    bus.not_pedaling = 1'b0;

    // Reset state.
    step();
    step();
    chk("rst_avg", bus.avg, 0);
    chk("rst_avg_vld", bus.avg_vld, 0);
    chk("rst_tick", bus.tick, 0);
    chk("rst_batt_ok", bus.batt_ok, 0);
    chk("rst_error", bus.error, 0);
    rst_n = 1'b1;

    // Constant input on ch0 with a strobe every cycle. Ch1 follows the timer with a random sample.
    bus.smpl[0 +: DW]  = 12'h400;
    bus.smpl[DW +: DW] = DW'($urandom_range(4095, 64));
    bus.strb[0]        = 1'b1;
    bus.target         = DW'($urandom);
    step();
    chk("first_strobe_avg0", bus.avg[0 +: DW], 12'h020);
    prev0 = bus.avg[0 +: DW];
    for (int k = 0; k < 400; k++) begin
      step();
      chk("avg0_monotonic", bus.avg[0 +: DW] >= prev0, 1);
      prev0 = bus.avg[0 +: DW];
    end
    chk("avg0_settled", bus.avg[0 +: DW], 12'h400);
    chk("first_tick_cycle", tick_at[0], P - 1);
    chk("acc1_nonzero", bus.avg[DW +: DW] != 0, 1);

    // Seed and tick in the same cycle. The seed value wins, and avg_vld pulses once.
    for (int k = 0; k < P + 4; k++) begin
      if (bus.tick === 1'b1) break;
      step();
    end
    chk("seed_tick_coincide", bus.tick, 1);
    chk("second_tick_cycle", tick_at[1], 2 * P - 1);
    bus.seed[1]        = 1'b1;
    bus.smpl[DW +: DW] = 12'h123;
    step();
    chk("seed_avg1", bus.avg[DW +: DW], 12'h123);
    chk("seed_vld1_high", bus.avg_vld[1], 1);
    bus.seed[1] = 1'b0;
    step();
    chk("seed_vld1_single", bus.avg_vld[1], 0);

    // Battery hysteresis sequence.
    bseq[0] = 12'hA00; bexp[0] = 1'b0;
    bseq[1] = 12'hAA0; bexp[1] = 1'b0;
    bseq[2] = 12'hAE0; bexp[2] = 1'b1;
    bseq[3] = 12'hAA0; bexp[3] = 1'b1;
    bseq[4] = 12'hA97; bexp[4] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.batt = bseq[k];
      step();
      step();
      step();
      chk("batt_ok_seq", bus.batt_ok, bexp[k]);
      if (!bexp[k]) chk("error_gated_lock", bus.error, 0);
    end

    // Error sign with avg0 settled at 0x180 and target 0x100.
    bus.batt          = 12'hC00;
    bus.smpl[0 +: DW] = 12'h180;
    for (int k = 0; k < 400; k++) step();
    chk("avg0_settled_180", bus.avg[0 +: DW], 12'h180);
    bus.target       = 12'h100;
    bus.not_pedaling = 1'b0;
    step();
    step();
    chk("error_negative", bus.error, 13'h1F80);
    bus.not_pedaling = 1'b1;
    step();
    chk("error_not_pedaling", bus.error, 0);

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      bus.smpl         = {DW'($urandom), DW'($urandom)};
      bus.strb         = NCH'($urandom);
      bus.seed         = {($urandom_range(15, 0) == 0), ($urandom_range(15, 0) == 0)};
      bus.batt         = DW'($urandom_range(12'hAF0, 12'hA80));
      bus.target       = DW'($urandom);
      bus.not_pedaling = ($urandom_range(7, 0) == 0);
      step();
    end

    // Reset during active strobes clears everything at once.
    bus.strb         = '1;
    bus.batt         = 12'hC00;
    bus.not_pedaling = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("async_rst_avg", bus.avg, 0);
    chk("async_rst_avg_vld", bus.avg_vld, 0);
    chk("async_rst_tick", bus.tick, 0);
    chk("async_rst_batt_ok", bus.batt_ok, 0);
    chk("async_rst_error", bus.error, 0);
    model_reset();
    tick_at[0] = -1;
    tick_at[1] = -1;
    step();
    step();
    rst_n             = 1'b1;
    bus.seed          = '0;
    bus.smpl[0 +: DW] = 12'h5A5;
    step();
    chk("post_rst_first_strobe", bus.avg[0 +: DW], 12'h02D);

    for (int k = 0; k < 100; k++) begin
      bus.smpl = {DW'($urandom), DW'($urandom)};
      bus.strb = NCH'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sensor_avg_bank.md
# sensor_avg_bank

Parametrised, multi-channel successor to the fixed current/torque conditioning path. It holds NCH independent exponential averagers. Each channel has its own weight shift, its own trigger source (free-running sample timer or external strobe) and a reseed input. A registered, gated error term is computed against a selected channel, and battery lockout uses hysteresis. It sits between the raw sensor/ADC sources and the drive controller (`desiredDrive` target in, PID error out).

## Interface
- NCH, 2, number of averaging channels (1..8)
- DW, 12, sample and average width (unsigned)
- SHIFT, 5, weight exponent S; each update keeps (2^S-1)/2^S of the old value (1..7)
- MODE, 'b01, bit i = 1: channel i updates on strb[i]; 0: updates on the internal timer tick
- TMR_W, 22, sample-timer width; tick period is 2^TMR_W cycles
- FAST_SIM, 0, when 1 the tick uses only timer bits [15:0] (period 2^16)
- ERR_CH, 0, channel index subtracted from target
- LOW_TH, 12'hA98, battery lockout-entry threshold
- HYST, 12'h040, lockout release at batt >= LOW_TH+HYST
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- smpl  in  NCH*DW  packed samples, channel i at [i*DW +: DW]
- strb  in  NCH  per-channel sample strobe (used only where MODE[i]=1)
- seed  in  NCH  per-channel reseed pulse
- target  in  DW  desired value for ERR_CH
- batt  in  DW  battery voltage sample
- not_pedaling  in  1  forces error to 0
- avg  out  NCH*DW  per-channel averages
- avg_vld  out  NCH  one-cycle pulse after channel i's accumulator changes
- tick  out  1  one-cycle timer-tick pulse
- batt_ok  out  1  registered battery-good flag with hysteresis
- error  out  DW+1  signed, registered target - avg[ERR_CH], gated

## Operation
- Accumulator per channel: AW = DW+SHIFT bits. avg[i] = acc[i][AW-1:SHIFT].
- Update on trigger: acc <= acc - (acc >> SHIFT) + smpl[i]. The result is exact and cannot overflow, because the max is (2^DW-1)<<SHIFT.
- Trigger source: strb[i] if MODE[i] else tick.
- Seed: acc <= smpl[i] << SHIFT, so avg equals the sample on the next cycle.
- Seed has priority over a simultaneous trigger. A seed and a trigger together give one update, with the seed value.
- avg_vld[i] is asserted the cycle after any seed or trigger update of channel i.
- Timer: tmr counts up from 0. tick is asserted combinationally when tmr is all ones (or tmr[15:0] is all ones under FAST_SIM), and tmr returns to 0 on that cycle.
- batt_ok state machine, two states:
  - LOCK (reset state) moves to OK when batt >= LOW_TH+HYST. Compute this in DW+1 bits; no wrap.
  - OK moves to LOCK when batt < LOW_TH.
  - Between the two thresholds the state holds.
- error: each cycle, error <= (not_pedaling | ~batt_ok) ? 0 : {1'b0,target} - {1'b0,avg[ERR_CH]} (two's complement, DW+1).

## Timing
- Reset values: every acc = 0, so avg = 0; avg_vld = 0; tmr = 0; tick = 0; batt_ok = 0 (LOCK); error = 0.
- Sample or seed in cycle n: acc and avg are updated at edge n+1, and avg_vld is high during cycle n+1.
- First tick occurs in cycle 2^TMR_W - 1 after reset release; after that, one tick every 2^TMR_W cycles.
- batt_ok changes 1 cycle after the threshold crossing. error reflects the inputs and avg of the previous cycle, so avg change to error change is 1 cycle.
- A strobe held high updates the channel every cycle it is high; edge detection is the source's job.
- Reset asserted mid-operation clears all state immediately, with no pending update.

## Test plan
- Constant input: DW=12, SHIFT=5, MODE[0]=1, smpl0=12'h400 with strb0 every cycle.
  - avg0 rises monotonically to 12'h400 and holds.
  - After 1 strobe from reset, acc0=0x400 and avg0=0x020.
- Seed and trigger together: acc1 nonzero, then seed1 and tick in the same cycle with smpl1=12'h123.
  - Next cycle avg1=12'h123, acc1=12'h123<<5, and avg_vld1 is a single pulse.
- Timer with FAST_SIM=1: tick first at cycle 65535 after reset, then at 131071.
  - A MODE=0 channel updates only on those cycles.
- Battery hysteresis sequence: batt 12'hA00, then 12'hAA0, then 12'hAE0, then 12'hAA0, then 12'hA97.
  - Required batt_ok: 0, 0, 1, 1, 0.
  - error is forced to 0 whenever batt_ok=0.
- Error sign: batt_ok=1, not_pedaling=0, target=12'h100, avg0 settled at 12'h180.
  - Required error=13'h1F80 (-128).
  - Raising not_pedaling gives error=0 on the next cycle.
- Mid-run reset: assert rst_n low while strobes are active.
  - All outputs are 0 asynchronously.
  - The first strobe after release gives avg0=smpl0>>SHIFT.
